// File: rtl/serial_packer_pkg.sv
// Shared types and helpers for the serial word packer.
// Imported by serial_packer_accum and serial_word_packer_obi.
package serial_packer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 3;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte-enable mask for a word holding cnt bytes, packed LSB-first.
    function automatic logic [BYTES_PER_WORD-1:0] be_mask(
        input logic [CNT_W-1:0] cnt
    );
        logic [BYTES_PER_WORD-1:0] m;
        m = '0;
        unique case (1'b1)
            (cnt == 3'd1): m = 4'b0001;
            (cnt == 3'd2): m = 4'b0011;
            (cnt == 3'd3): m = 4'b0111;
            (cnt == 3'd4): m = 4'b1111;
            default:       m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/serial_packer_accum.sv
// Byte assembler: packs bytes LSB-first and flags a finished word.
// Exposes an idle-step strobe only when SERIAL_PACKER_IDLE_FLUSH_EN is set.
module serial_packer_accum
    import serial_packer_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      i_en,
    input  logic                      i_byte_valid,
    input  logic [7:0]                i_byte_data,
    input  logic                      i_flush,
`ifdef SERIAL_PACKER_IDLE_FLUSH_EN
    output logic                      o_idle_step,
`endif
    output logic                      o_word_valid,
    output logic [WORD_W-1:0]         o_word,
    output logic [BYTES_PER_WORD-1:0] o_be
);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_asm;

    logic              w_take;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-1:0] w_asm_nxt;
    logic              w_full;
    logic              w_flush_hit;

    assign w_take    = i_en & i_byte_valid;
    assign w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, w_take};

    always_comb begin
        w_asm_nxt = r_asm;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (w_take && (r_cnt == CNT_W'(b))) begin
                w_asm_nxt[8*b +: 8] = i_byte_data;
            end
        end
    end

    // A byte arriving with flush counts first, so flush sees the new count.
    assign w_full       = (w_cnt_nxt == CNT_W'(BYTES_PER_WORD));
    assign w_flush_hit  = i_en & i_flush & (w_cnt_nxt != '0);
    assign o_word_valid = w_full | w_flush_hit;
    assign o_word       = w_asm_nxt;
    assign o_be         = be_mask(w_cnt_nxt);

`ifdef SERIAL_PACKER_IDLE_FLUSH_EN
    assign o_idle_step = i_en & (r_cnt != '0) & ~w_take;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (o_word_valid) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_asm <= w_asm_nxt;
        end
    end

endmodule

// File: rtl/serial_word_packer_obi.sv
// Packs a byte stream into 32-bit OBI writes, one outstanding at a time.
// Optional idle auto-flush is enabled by SERIAL_PACKER_IDLE_FLUSH_EN.
module serial_word_packer_obi
    import serial_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR    = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    input  logic                  flush_i,
    output logic                  req_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  busy_o,
    output logic [15:0]           words_sent_o
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
    begin : g_bad_param
        $error("serial_word_packer_obi: unsupported parameters");
    end

    state_e r_state;
    state_e w_state_nxt;

    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [BYTES_PER_WORD-1:0] r_be;
    logic [15:0]               r_sent;

    logic                      w_fill;
    logic                      w_flush;
    logic                      w_idle_hit;
    logic                      w_word_valid;
    logic [WORD_W-1:0]         w_word;
    logic [BYTES_PER_WORD-1:0] w_be;

    assign w_fill  = (r_state == ST_FILL);
    assign w_flush = flush_i | w_idle_hit;

`ifdef SERIAL_PACKER_IDLE_FLUSH_EN
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_idle;
    logic       w_idle_step;

    assign w_idle_hit = w_fill & (r_idle == IDLE_LIMIT);

    // Counts only while a partial word sits untouched in FILL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle <= '0;
        end else if (w_idle_step && !w_word_valid) begin
            r_idle <= r_idle + 8'd1;
        end else begin
            r_idle <= '0;
        end
    end
`else
    assign w_idle_hit = 1'b0;
`endif

    serial_packer_accum u_accum (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_en         (w_fill),
        .i_byte_valid (byte_valid_i),
        .i_byte_data  (byte_data_i),
        .i_flush      (w_flush),
`ifdef SERIAL_PACKER_IDLE_FLUSH_EN
        .o_idle_step  (w_idle_step),
`endif
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_be         (w_be)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        byte_ready_o = 1'b0;
        req_o        = 1'b0;
        we_o         = 1'b0;
        busy_o       = 1'b1;
        unique case (r_state)
            ST_FILL: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b0;
                if (w_word_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                req_o = 1'b1;
                we_o  = 1'b1;
                if (gnt_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rvalid_i) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // Word and enables are captured at launch and held through the handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdata <= '0;
            r_be    <= '0;
            r_sent  <= '0;
        end else if (w_fill && w_word_valid) begin
            r_wdata <= w_word;
            r_be    <= w_be;
        end else if (r_state == ST_RESP && rvalid_i) begin
            r_be   <= '0;
            r_sent <= r_sent + 16'd1;
        end
    end

    assign addr_o       = TARGET_ADDR;
    assign be_o         = r_be;
    assign wdata_o      = r_wdata;
    assign words_sent_o = r_sent;

endmodule

// File: doc/serial_word_packer_obi.md
Name: serial_word_packer_obi

Overview:
- Upstream producer for the serial-link FIFO wrapper's writer port.
- Accepts a byte stream from the serial-link receiver and packs the bytes LSB-first into 32-bit words.
- Issues each word as a single OBI write to the FIFO writer port: one transaction outstanding at a time, full req/gnt/rvalid handshake.
- Supports partial-word flush: `be_o` marks which bytes are valid.

Parameters:
- DATA_WIDTH, 32, OBI data width; only 32 is supported.
- ADDR_WIDTH, 32, OBI address width.
- TARGET_ADDR, 32'h0, constant address driven on `addr_o`.
- TIMEOUT_CYCLES, 255, idle cycles before auto-flush (used only with the optional feature); 8-bit range, minimum 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- byte_valid_i  in  1  input byte valid.
- byte_data_i  in  8  input byte.
- byte_ready_o  out  1  byte accepted when valid and ready are both high.
- flush_i  in  1  single-cycle pulse that emits the partial word.
- req_o  out  1  OBI request.
- gnt_i  in  1  OBI grant.
- rvalid_i  in  1  OBI response valid.
- addr_o  out  ADDR_WIDTH  always TARGET_ADDR.
- we_o  out  1  OBI write enable.
- be_o  out  4  OBI byte enables.
- wdata_o  out  DATA_WIDTH  OBI write data.
- busy_o  out  1  high in REQ or RESP.
- words_sent_o  out  16  count of completed writes.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - state = FILL, byte count = 0.
  - byte_ready_o = 1, req_o = 0, we_o = 0, be_o = 0, wdata_o = 0, busy_o = 0, words_sent_o = 0.
  - addr_o = TARGET_ADDR at all times.
- Asserting reset mid-operation discards any partial word and any in-flight request with no further OBI activity. No response is awaited after reset.
- FSM states: FILL, REQ, RESP.
- FILL:
  - byte_ready_o = 1.
  - An accepted byte is written to bits [8*cnt+7 : 8*cnt], then cnt increments.
  - When the 4th byte is accepted, the next state is REQ with be_o = 4'hF.
  - Unused bytes of a word are zero.
- Flush:
  - flush_i in FILL with post-accept cnt 1, 2 or 3: next state is REQ with be_o = 4'b0001, 4'b0011 or 4'b0111 respectively.
  - flush_i with cnt 0: ignored.
  - flush_i in REQ or RESP: ignored and not remembered.
  - Byte and flush_i in the same cycle: the byte is taken first, then flush applies to the updated count. If cnt reaches 4, this is an ordinary full word.
- REQ:
  - req_o = 1, we_o = 1, byte_ready_o = 0.
  - wdata_o and be_o stay stable until grant.
  - gnt_i = 1 ends the request: next state is RESP and req_o drops the following cycle.
  - With gnt_i = 0 (FIFO full), the block holds indefinitely.
- RESP:
  - req_o = 0, byte_ready_o = 0.
  - rvalid_i = 1: next state is FILL, cnt = 0, be_o = 0, words_sent_o increments (wraps 16'hFFFF -> 0).
  - rvalid_i outside RESP is ignored.
- Latency: 4th byte accepted at cycle t -> req_o high at t+1. With gnt at t+1 and rvalid at t+2, byte_ready_o returns high at t+3.
- busy_o = (state != FILL), decoded from the state register.

Optional Feature:
- Macro: SERIAL_PACKER_IDLE_FLUSH_EN.
- Defined:
  - An 8-bit idle counter runs in FILL while cnt > 0 and no byte is accepted.
  - The counter clears on byte acceptance, on leaving FILL, and on reset.
  - When the counter reaches TIMEOUT_CYCLES, the block behaves exactly as if flush_i had been asserted that cycle.
- Undefined: no counter exists, TIMEOUT_CYCLES is unused, and partial words leave only via flush_i.

Decomposition:
- Package serial_packer_pkg contains:
  - state enum typedef (FILL, REQ, RESP);
  - BYTES_PER_WORD = 4;
  - function be_mask(cnt) returning 4'b0001 / 0011 / 0111 / 1111.
- Sub-module serial_packer_accum holds the byte count, assembly register and be generation (byte in, flush in -> word_valid, word, be out).
- The top level owns the FSM, the OBI handshake, the words_sent counter and the optional idle timer.

Test Plan:
- Full word: bytes 0x11, 0x22, 0x33, 0x44 back-to-back, gnt=1, rvalid one cycle later -> one write, wdata_o = 32'h44332211, be_o = 4'hF, addr_o = TARGET_ADDR, words_sent_o = 1, byte_ready_o high 3 cycles after the 4th byte.
- Partial flush: bytes 0xAA, 0xBB then flush_i -> wdata_o = 32'h0000BBAA, be_o = 4'b0011. flush_i with cnt 0 -> req_o stays 0.
- Simultaneous: 3rd byte 0xCC together with flush_i -> be_o = 4'b0111 and wdata_o[23:16] = 8'hCC. 4th byte with flush_i -> be_o = 4'hF.
- Backpressure: gnt_i held 0 for 20 cycles -> req_o stays 1, wdata_o/be_o stable, byte_ready_o = 0, no byte lost; grant released -> exactly one write.
- Reset in REQ: rst_ni low while req_o = 1 -> all outputs return to reset values immediately; the next 4 bytes produce a clean word with words_sent_o = 1.
- Idle flush (macro defined, TIMEOUT_CYCLES = 10): single byte 0x5A then idle -> req_o rises on the cycle after the timer reaches 10, be_o = 4'b0001, wdata_o = 32'h5A. Without the macro -> no request.
